memory_port_arbiter: RTL

//  Shares one single-port, variable-latency memory between instruction fetch and data load/store for the RV32I46F core.

---
 rtl/memory_port_arbiter_pkg.sv | 19 +
 rtl/access_timer.sv | 29 ++
 rtl/memory_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// rtl/memory_port_arbiter_pkg.sv - shared state encoding and helpers for the memory port arbiter
package memory_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_DM = 2'd1,
        ARB_BUSY_IF = 2'd2
    } arb_state_t;

    localparam int ARB_ADDR_WIDTH     = 32;
    localparam int ARB_DATA_WIDTH     = 32;
    localparam int ARB_TIMEOUT_CYCLES = 16;

    // A counter needs at least one bit even for the smallest legal timeout.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/access_timer.sv
// rtl/access_timer.sv - counts busy cycles and flags the last cycle before an access fault
module access_timer
    import memory_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = timer_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one variable-latency memory port between fetch and load/store
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_ready,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_wmask,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_ready,
    output logic                    write_done,
    output logic                    access_fault,
    output logic                    fault_is_data,
    output logic                    core_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    arb_state_t state_q, state_d;
    logic       grant_dm, grant_if;
    logic       done, timed_out;
    logic       busy, expired;
    logic       ready_pulse;

    assign busy        = (state_q != ARB_IDLE);
    assign ready_pulse = if_ready | dm_ready;
    assign core_stall  = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (done | timed_out | ~busy),
        .run     (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The cycle carrying a ready pulse never grants, so each completion is
    // followed by one IDLE cycle before the next transaction starts.
    always_comb begin
        state_d   = state_q;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!ready_pulse) begin
                    if (dm_req) begin
                        grant_dm = 1'b1;
                        state_d  = ARB_BUSY_DM;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                        state_d  = ARB_BUSY_IF;
                    end
                end
            end
            ARB_BUSY_DM, ARB_BUSY_IF: begin
                if (mem_ack) begin
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end else if (expired) begin
                    timed_out = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_rdata      <= '0;
            dm_rdata      <= '0;
            if_ready      <= 1'b0;
            dm_ready      <= 1'b0;
            write_done    <= 1'b0;
            access_fault  <= 1'b0;
            fault_is_data <= 1'b0;
        end else begin
            if_ready      <= 1'b0;
            dm_ready      <= 1'b0;
            write_done    <= 1'b0;
            access_fault  <= 1'b0;
            fault_is_data <= 1'b0;

            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_wmask <= dm_wmask;
            end else if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wmask <= '0;
            end

            if (done || timed_out) begin
                mem_req       <= 1'b0;
                access_fault  <= timed_out;
                fault_is_data <= timed_out && (state_q == ARB_BUSY_DM);
                if (state_q == ARB_BUSY_DM) begin
                    dm_ready   <= 1'b1;
                    write_done <= done & mem_we;
                    // A completed store leaves the last load data in place.
                    if (timed_out) begin
                        dm_rdata <= '0;
                    end else if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= timed_out ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule
